// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the rx FIFO and its consumer.
// slave is the FIFO side; master is the receiver/consumer side.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_done;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] level;
  logic          almost_full;
  logic          overflow;
  logic          ovf_clear;

  modport slave (
    input  rx_data, rx_done, m_ready, ovf_clear,
    output m_data, m_valid, level, almost_full, overflow
  );

  modport master (
    output rx_data, rx_done, m_ready, ovf_clear,
    input  m_data, m_valid, level, almost_full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver.
// Pushes on rx_done, pops on m_valid & m_ready, reports level, almost_full
// and a sticky overflow flag. All outputs come straight from registers.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf;

  logic full, empty, push, pop, drop;

  // Handshake decode: a full FIFO still accepts a byte when one leaves the
  // same cycle, so only full-without-pop drops.
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    pop   = !empty && bus.m_ready;
    push  = bus.rx_done && (!full || pop);
    drop  = bus.rx_done && full && !pop;
  end

  // Storage and write pointer; reset clears the array so m_data reads 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.rx_data;
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk) begin
    if (!rst_n)   rd_ptr <= '0;
    else if (pop) rd_ptr <= rd_ptr + AW'(1);
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n)             ovf <= 1'b0;
    else if (drop)          ovf <= 1'b1;
    else if (bus.ovf_clear) ovf <= 1'b0;
  end

  // Outputs derived only from registered state.
  always_comb begin
    bus.m_data      = mem[rd_ptr];
    bus.m_valid     = !empty;
    bus.level       = count;
    bus.almost_full = (count >= CW'(AFULL_THRESH));
    bus.overflow    = ovf;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a table of per-cycle vectors with
// hand-computed expectations, then a reset-mid-burst sequence checked
// against a small queue model.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(16)) bus();

  uart_rx_fifo #(.DEPTH(16), .AFULL_THRESH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       m_ready;
    logic       ovf_clear;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] el;
    logic       eaf;
    logic       eov;
    logic       chk_d;
  } vec_t;

  vec_t vecs[$];
  int   npass = 0;
  int   ntot  = 0;

  function automatic void add(input logic r, input logic d, input logic [7:0] x,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [7:0] ed, input logic [4:0] el,
                              input logic eaf, input logic eov, input logic cd);
    vec_t v;
    v.rst_n = r; v.rx_done = d; v.rx_data = x; v.m_ready = rdy; v.ovf_clear = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.eaf = eaf; v.eov = eov; v.chk_d = cd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s @%0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
  endtask

  task automatic drive(input logic r, input logic d, input logic [7:0] x,
                       input logic rdy, input logic clr);
    rst_n         = r;
    bus.rx_done   = d;
    bus.rx_data   = x;
    bus.m_ready   = rdy;
    bus.ovf_clear = clr;
  endtask

  // Reference queue for the reset/wrap sequence.
  logic [7:0] q[$];
  logic       mov;

  task automatic cyc(input int idx, input logic r, input logic d, input logic [7:0] x,
                     input logic rdy, input logic clr);
    logic p, f, pu, dr;
    drive(r, d, x, rdy, clr);
    if (!r) begin
      q.delete();
      mov = 1'b0;
    end else begin
      p  = (q.size() != 0) && rdy;
      f  = (q.size() == 16);
      pu = d && (!f || p);
      dr = d && f && !p;
      if (p)  void'(q.pop_front());
      if (pu) q.push_back(x);
      if (dr) mov = 1'b1;
      else if (clr) mov = 1'b0;
    end
    @(posedge clk); #1;
    check("seq_valid", idx, 32'(bus.m_valid), 32'(q.size() != 0));
    check("seq_level", idx, 32'(bus.level), 32'(q.size()));
    check("seq_afull", idx, 32'(bus.almost_full), 32'(q.size() >= 12));
    check("seq_ovf",   idx, 32'(bus.overflow), 32'(mov));
    if (q.size() != 0) check("seq_data", idx, 32'(bus.m_data), 32'(q[0]));
    else if (!r)       check("seq_rst_data", idx, 32'(bus.m_data), 32'h0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] hd;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // r  d  data  rdy clr | v  data  lvl af ov chk_d
    add(0, 1, 8'hEE, 0, 0,   0, 8'h00, 0, 0, 0, 1);  // reset, rx_done ignored
    add(1, 1, 8'hA5, 0, 0,   1, 8'hA5, 1, 0, 0, 1);  // single push
    add(1, 0, 8'h00, 0, 0,   1, 8'hA5, 1, 0, 0, 1);  // held, no pop
    add(1, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0, 0);  // pop
    add(1, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0, 0);  // m_ready while empty
    add(1, 1, 8'h3C, 1, 0,   1, 8'h3C, 1, 0, 0, 1);  // push into empty, no bypass pop
    add(1, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)                     // fill 0x00..0x0F
      add(1, 1, 8'(i), 0, 0, 1, 8'h00, 5'(i + 1), (i + 1) >= 12, 0, 1);
    add(1, 1, 8'h55, 0, 0,   1, 8'h00, 16, 1, 1, 1); // drop when full
    add(1, 0, 8'h00, 0, 1,   1, 8'h00, 16, 1, 0, 1); // clear
    add(1, 1, 8'h66, 0, 1,   1, 8'h00, 16, 1, 1, 1); // drop wins over clear
    add(1, 0, 8'h00, 0, 1,   1, 8'h00, 16, 1, 0, 1);
    add(1, 1, 8'h77, 1, 0,   1, 8'h01, 16, 1, 0, 1); // full push+pop
    for (int j = 1; j <= 16; j++) begin               // drain 01..0F, 77
      hd = (j < 15) ? 8'(j + 1) : 8'h77;
      add(1, 0, 8'h00, 1, 0, j < 16, hd, 5'(16 - j), (16 - j) >= 12, 0, j < 16);
    end

    @(posedge clk); #1;
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      drive(v.rst_n, v.rx_done, v.rx_data, v.m_ready, v.ovf_clear);
      @(posedge clk); #1;
      check("valid", k, 32'(bus.m_valid), 32'(v.ev));
      check("level", k, 32'(bus.level), 32'(v.el));
      check("afull", k, 32'(bus.almost_full), 32'(v.eaf));
      check("ovf",   k, 32'(bus.overflow), 32'(v.eov));
      if (v.chk_d) check("data", k, 32'(bus.m_data), 32'(v.ed));
    end

    // Reset mid-burst, then a long burst that wraps the pointers.
    q.delete();
    mov = 1'b0;
    for (int i = 0; i < 10; i++)
      cyc(100 + i, 1'b1, 1'b1, 8'hB0 + 8'(i), 1'($urandom_range(0, 1)), 1'b0);
    cyc(110, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++)
      cyc(111 + i, 1'b1, 1'b1, 8'hC0 + 8'(i), 1'($urandom_range(0, 3) != 0), 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(141 + i, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
